sram_1rw1r_initiator: RTL and testbench

Single-clock initiator that drives the two ports of an OpenRAM 1rw1r macro (8-bit × 1024) from two valid/ready request streams. It registers all macro control pins and captures read data at the correct clock edge. It returns read data on per-port response streams with backpressure. It resolves same-address write/read collisions between the ports and optionally zero-fills the array after reset. It sits between the port arbiters and the macro instance in the triple-ported memory wrapper.

---
 rtl/sram_1rw1r_initiator.sv | 214 +++++++++++++++++++++
 tb/tb_sram_1rw1r_initiator.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_initiator.sv
// Initiator for an OpenRAM 1rw1r macro: registered macro pins, 2-cycle read capture, per-port response FIFOs.
// Optional feature: define SRAM_INIT_CLEAR_EN to zero-fill the array through port 0 after reset.

module sram_rsp_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] rdata
);

  logic [W-1:0] slot0, slot1;
  logic         wr_ptr, rd_ptr;
  logic [1:0]   used;
  logic         do_pop;

  assign valid  = (used != 2'd0);
  assign do_pop = pop && valid;
  assign rdata  = rd_ptr ? slot1 : slot0;

  // First-word fall-through: the head slot is presented combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      used   <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= wdata;
        else        slot0 <= wdata;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      used <= used + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

module sram_1rw1r_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic                  init_done
);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_issue, clr_last;

  logic       a_pop, b_pop, a_rd_ok, b_rd_ok;
  logic       a_acc, a_wr_acc, a_rd_acc, b_acc, collide;
  logic [1:0] a_cnt, b_cnt;
  logic       a_s1, a_s2, b_s1, b_s2;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef SRAM_INIT_CLEAR_EN
      ST_RESET: state_nxt = ST_CLEAR;
`else
      ST_RESET: state_nxt = ST_RUN;
`endif
      ST_CLEAR: if (clr_last) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // The clear sweep starts on the first edge out of reset, so address 0 is written while still in RESET.
  always_comb begin
    init_done = (state == ST_RUN);
    clr_issue = 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
    clr_issue = (state == ST_RESET) || (state == ST_CLEAR);
`endif
    clr_last  = (state == ST_CLEAR) && (clr_addr == '1);
  end

  always_ff @(posedge clk) begin
    if (rst)            clr_addr <= '0;
    else if (clr_issue) clr_addr <= clr_addr + 1'b1;
  end

  // The outstanding count covers reads in the macro pipeline plus those buffered, so the FIFO never overflows.
  assign a_pop    = a_rsp_valid && a_rsp_ready;
  assign b_pop    = b_rsp_valid && b_rsp_ready;
  assign a_rd_ok  = (a_cnt < 2'd2) || a_pop;
  assign b_rd_ok  = (b_cnt < 2'd2) || b_pop;

  assign a_req_ready = init_done && (a_req_we || a_rd_ok);
  assign a_acc       = a_req_valid && a_req_ready;
  assign a_wr_acc    = a_acc && a_req_we;
  assign a_rd_acc    = a_acc && !a_req_we;
  assign collide     = a_wr_acc && (a_req_addr == b_req_addr);
  assign b_req_ready = init_done && b_rd_ok && !collide;
  assign b_acc       = b_req_valid && b_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt <= 2'd0;
      b_cnt <= 2'd0;
    end else begin
      a_cnt <= a_cnt + {1'b0, a_rd_acc} - {1'b0, a_pop};
      b_cnt <= b_cnt + {1'b0, b_acc} - {1'b0, b_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (clr_issue) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b0;
      sram_addr0 <= clr_addr;
      sram_din0  <= '0;
    end else if (a_acc) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= !a_req_we;
      sram_addr0 <= a_req_addr;
      sram_din0  <= a_req_wdata;
    end else begin
      sram_csb0  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
    end else if (b_acc) begin
      sram_csb1  <= 1'b0;
      sram_addr1 <= b_req_addr;
    end else begin
      sram_csb1  <= 1'b1;
    end
  end

  // Stage 2 flags mark the edge on which the macro's dout holds this read's data and must be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= a_rd_acc;
      a_s2 <= a_s1;
      b_s1 <= b_acc;
      b_s2 <= b_s1;
    end
  end

  sram_rsp_fifo #(.W(DATA_WIDTH)) u_a_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (a_s2),
    .wdata (sram_dout0),
    .pop   (a_rsp_ready),
    .valid (a_rsp_valid),
    .rdata (a_rsp_rdata)
  );

  sram_rsp_fifo #(.W(DATA_WIDTH)) u_b_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (b_s2),
    .wdata (sram_dout1),
    .pop   (b_rsp_ready),
    .valid (b_rsp_valid),
    .rdata (b_rsp_rdata)
  );

endmodule

// File: tb/tb_sram_1rw1r_initiator.sv
// Directed bench for sram_1rw1r_initiator with a behavioural 1rw1r macro model.
// Define SRAM_INIT_CLEAR_EN to also exercise the post-reset clear sweep.

module tb_sram_1rw1r_initiator;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam logic [DW-1:0] POISON = 8'hEE;
`ifdef SRAM_INIT_CLEAR_EN
  localparam int INIT_CYC = 1024;
`else
  localparam int INIT_CYC = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          a_rsp_valid, a_rsp_ready;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_valid, b_req_ready;
  logic [AW-1:0] b_req_addr;
  logic          b_rsp_valid, b_rsp_ready;
  logic [DW-1:0] b_rsp_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] m_dout0 = '0;
  logic [DW-1:0] m_dout1 = '0;
  logic          init_done;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];

  always #5 clk = ~clk;

  sram_1rw1r_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_we    (a_req_we),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_ready (a_rsp_ready),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_addr  (b_req_addr),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_ready (b_rsp_ready),
    .b_rsp_rdata (b_rsp_rdata),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (m_dout0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (m_dout1),
    .init_done   (init_done)
  );

  // Macro model: samples pins at the edge, glitches dout to a poison value, then settles to read data.
  always @(posedge clk) begin : macro_model
    logic          rd0, rd1, wr0;
    logic [DW-1:0] d0, d1;
    wr0 = !sram_csb0 && !sram_web0;
    rd0 = !sram_csb0 && sram_web0;
    rd1 = !sram_csb1;
    d0  = mem[sram_addr0];
    d1  = (wr0 && sram_addr0 == sram_addr1) ? POISON : mem[sram_addr1];
    if (wr0) mem[sram_addr0] = sram_din0;
    #1;
    if (rd0) m_dout0 = POISON;
    if (rd1) m_dout1 = POISON;
    #2;
    if (rd0) m_dout0 = d0;
    if (rd1) m_dout1 = d1;
  end

  always @(negedge clk) begin
    #2;
    if (a_rsp_valid && a_rsp_ready) a_q.push_back(a_rsp_rdata);
    if (b_rsp_valid && b_rsp_ready) b_q.push_back(b_rsp_rdata);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle_inputs();
    a_req_valid = 1'b0;
    a_req_we    = 1'b0;
    a_req_addr  = '0;
    a_req_wdata = '0;
    b_req_valid = 1'b0;
    b_req_addr  = '0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 1100) begin
      @(negedge clk);
      n++;
      if (init_done) break;
    end
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = addr;
    a_req_wdata = data;
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle_inputs();
    a_req_we = 1'b1;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_csb0, sram_csb1, sram_web0} !== 3'b111) begin
      failures++; $display("[TB] FAIL reset_ctrl got=%b exp=111", {sram_csb0, sram_csb1, sram_web0});
    end
    checks++;
    if ({sram_addr0, sram_din0, sram_addr1} !== 28'd0) begin
      failures++; $display("[TB] FAIL reset_addr_din got=%h exp=0", {sram_addr0, sram_din0, sram_addr1});
    end
    checks++;
    if ({a_rsp_valid, b_rsp_valid, a_rsp_rdata, b_rsp_rdata} !== 18'd0) begin
      failures++; $display("[TB] FAIL reset_rsp got=%h exp=0", {a_rsp_valid, b_rsp_valid, a_rsp_rdata, b_rsp_rdata});
    end
    checks++;
    if ({init_done, a_req_ready, b_req_ready} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=000", {init_done, a_req_ready, b_req_ready});
    end
    a_req_we = 1'b0;
    rst = 1'b0;
    wait_init(n);
    checks++;
    if (n !== INIT_CYC) begin
      failures++; $display("[TB] FAIL init_latency got=%0d exp=%0d", n, INIT_CYC);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 10'h123; a_req_wdata = 8'hA5;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL wr_ready got=%b exp=1", a_req_ready);
    end
    @(negedge clk);
    checks++;
    if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b0, 1'b0, 10'h123, 8'hA5}) begin
      failures++; $display("[TB] FAIL wr_pins got=%h exp=%h", {sram_csb0, sram_web0, sram_addr0, sram_din0}, {1'b0, 1'b0, 10'h123, 8'hA5});
    end
    a_req_we = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rd_ready got=%b exp=1", a_req_ready);
    end
    @(negedge clk);
    checks++;
    if ({sram_csb0, sram_web0, sram_addr0} !== {1'b0, 1'b1, 10'h123}) begin
      failures++; $display("[TB] FAIL rd_pins got=%h exp=%h", {sram_csb0, sram_web0, sram_addr0}, {1'b0, 1'b1, 10'h123});
    end
    a_req_valid = 1'b0;
    checks++;
    if (a_rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rd_lat0 got=%b exp=0", a_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({a_rsp_valid, sram_csb0} !== 2'b01) begin
      failures++; $display("[TB] FAIL rd_lat1 got=%b exp=01", {a_rsp_valid, sram_csb0});
    end
    @(negedge clk);
    checks++;
    if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 8'hA5}) begin
      failures++; $display("[TB] FAIL rd_lat2_data got=%h exp=%h", {a_rsp_valid, a_rsp_rdata}, {1'b1, 8'hA5});
    end
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rd_popped got=%b exp=0", a_rsp_valid);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 10'h011; a_req_wdata = 8'h77;
    b_req_valid = 1'b1; b_req_addr = 10'h012;
    #1;
    checks++;
    if (b_req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL diff_addr_ready got=%b exp=1", b_req_ready);
    end
    @(negedge clk);
    a_req_addr = 10'h010; a_req_wdata = 8'h3C;
    b_req_addr = 10'h010;
    #1;
    checks++;
    if ({a_req_ready, b_req_ready} !== 2'b10) begin
      failures++; $display("[TB] FAIL coll_deny got=%b exp=10", {a_req_ready, b_req_ready});
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    checks++;
    if (b_req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL coll_retry got=%b exp=1", b_req_ready);
    end
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++;
    if ({sram_csb1, sram_addr1} !== {1'b0, 10'h010}) begin
      failures++; $display("[TB] FAIL coll_pins got=%h exp=%h", {sram_csb1, sram_addr1}, {1'b0, 10'h010});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({b_rsp_valid, b_rsp_rdata} !== {1'b1, 8'h3C}) begin
      failures++; $display("[TB] FAIL coll_data got=%h exp=%h", {b_rsp_valid, b_rsp_rdata}, {1'b1, 8'h3C});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc;
    logic last_ready;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b1;
      a_req_addr = 10'h040 + 10'(i); a_req_wdata = 8'h80 + 8'(i);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    b_rsp_ready = 1'b0;
    b_q.delete();
    acc = 0;
    last_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_addr  = 10'h040 + 10'(acc);
      #1;
      last_ready = b_req_ready;
      if (b_req_ready) acc++;
    end
    checks++;
    if (acc !== 2) begin
      failures++; $display("[TB] FAIL bp_accepted got=%0d exp=2", acc);
    end
    checks++;
    if ({last_ready, b_rsp_valid} !== 2'b01) begin
      failures++; $display("[TB] FAIL bp_stalled got=%b exp=01", {last_ready, b_rsp_valid});
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      b_rsp_ready = 1'b1;
      b_req_valid = (acc < 4);
      b_req_addr  = 10'h040 + 10'(acc);
      #1;
      if (b_req_valid && b_req_ready) acc++;
      if (acc == 4 && b_q.size() == 4) break;
    end
    b_req_valid = 1'b0;
    checks++;
    if (acc !== 4 || b_q.size() !== 4) begin
      failures++; $display("[TB] FAIL bp_drain got=%0d/%0d exp=4/4", acc, b_q.size());
    end
    for (int i = 0; i < 4 && i < b_q.size(); i++) begin
      checks++;
      if (b_q[i] !== 8'h80 + 8'(i)) begin
        failures++; $display("[TB] FAIL bp_order%0d got=%h exp=%h", i, b_q[i], 8'h80 + 8'(i));
      end
    end
  endtask

  task automatic test_stream();
    int a_acc, b_acc, bad;
    a_write(10'h3FF, 8'h5A);
    @(negedge clk);
    a_q.delete();
    b_q.delete();
    a_acc = 0;
    b_acc = 0;
    for (int c = 0; c < 100; c++) begin
      a_req_valid = (a_acc < 16); a_req_we = 1'b0; a_req_addr = 10'h3FF;
      b_req_valid = (b_acc < 16); b_req_addr = 10'h3FF;
      #1;
      if (a_req_valid && a_req_ready) a_acc++;
      if (b_req_valid && b_req_ready) b_acc++;
      @(negedge clk);
      if (a_q.size() == 16 && b_q.size() == 16) break;
    end
    idle_inputs();
    checks++;
    if (a_acc !== 16 || b_acc !== 16) begin
      failures++; $display("[TB] FAIL stream_accepts got=%0d/%0d exp=16/16", a_acc, b_acc);
    end
    checks++;
    if (a_q.size() !== 16 || b_q.size() !== 16) begin
      failures++; $display("[TB] FAIL stream_rsps got=%0d/%0d exp=16/16", a_q.size(), b_q.size());
    end
    bad = 0;
    foreach (a_q[i]) if (a_q[i] !== 8'h5A) bad++;
    foreach (b_q[i]) if (b_q[i] !== 8'h5A) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("[TB] FAIL stream_data got=%0d_bad exp=0_bad", bad);
    end
  endtask

  task automatic test_reset_inflight();
    int seen, n;
    a_write(10'h077, 8'h11);
    a_q.delete();
    b_q.delete();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'h077;
    b_req_valid = 1'b1; b_req_addr = 10'h077;
    @(negedge clk);
    b_req_valid = 1'b0;
    a_req_addr = 10'h078;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_csb0, sram_csb1, a_rsp_valid, b_rsp_valid} !== 4'b1100) begin
      failures++; $display("[TB] FAIL rstfl_pins got=%b exp=1100", {sram_csb0, sram_csb1, a_rsp_valid, b_rsp_valid});
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_rsp_valid || b_rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || a_q.size() !== 0 || b_q.size() !== 0) begin
      failures++; $display("[TB] FAIL rstfl_no_rsp got=%0d exp=0", seen + a_q.size() + b_q.size());
    end
    checks++;
    if ({a_rsp_rdata, b_rsp_rdata} !== 16'h0000) begin
      failures++; $display("[TB] FAIL rstfl_rdata got=%h exp=0000", {a_rsp_rdata, b_rsp_rdata});
    end
    wait_init(n);
    checks++;
    if (init_done !== 1'b1) begin
      failures++; $display("[TB] FAIL rstfl_init got=%b exp=1", init_done);
    end
  endtask

`ifdef SRAM_INIT_CLEAR_EN
  task automatic test_clear();
    int n, busy;
    a_write(10'h200, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    busy = 0;
    while (n < 1100) begin
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'h200;
      b_req_valid = 1'b1; b_req_addr = 10'h200;
      #1;
      if (n == 10) busy = {a_req_ready, b_req_ready};
      @(negedge clk);
      n++;
      if (init_done) break;
    end
    idle_inputs();
    checks++;
    if (busy !== 0) begin
      failures++; $display("[TB] FAIL clear_ready got=%0d exp=0", busy);
    end
    checks++;
    if (n !== 1024) begin
      failures++; $display("[TB] FAIL clear_latency got=%0d exp=1024", n);
    end
    a_q.delete();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'h200;
    @(negedge clk);
    a_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (a_q.size() !== 1 || a_q[0] !== 8'h00) begin
      failures++; $display("[TB] FAIL clear_data got=%0d/%h exp=1/00", a_q.size(), (a_q.size() > 0) ? a_q[0] : POISON);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_collision();
    test_backpressure();
    test_stream();
    test_reset_inflight();
`ifdef SRAM_INIT_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
